// File: rtl/sr_bank_sched.sv
// Sequencer/arbiter driving the shared d/s/r/enable controls of an SR flop bank.
// Optional build macro SR_BANK_SCHED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module sr_bank_sched #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int PULSE    = 2,
   parameter int RECOVERY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [2*NREQ-1:0]       op,
   input  logic [WIDTH*NREQ-1:0]   wdata,
   output logic [NREQ-1:0]         grant,
   output logic                    done,
   output logic                    err,
   output logic                    bank_en,
   output logic [WIDTH-1:0]        bank_d,
   output logic [WIDTH-1:0]        bank_s,
   output logic [WIDTH-1:0]        bank_r
);

   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int MAXC = (PULSE > RECOVERY) ? PULSE : RECOVERY;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, DRIVE, RECOVER} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [1:0]        lop, lop_nxt;
   logic [WIDTH-1:0]  ldata, ldata_nxt;
   logic [NREQ-1:0]   grant_nxt;
   logic              done_nxt, err_nxt, en_nxt;
   logic [WIDTH-1:0]  d_nxt, s_nxt, r_nxt;
   logic              win_valid;
   logic [PW-1:0]     win_idx;
   logic [1:0]        win_op;
   logic [WIDTH-1:0]  win_data;

`ifndef SR_BANK_SCHED_PRIORITY_EN
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     widx;

   // Pointer moves past the winner only once its operation completes, so an aborted op keeps its turn
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= '0;
         widx <= '0;
      end else begin
         if (state == IDLE && win_valid)
            widx <= win_idx;
         if (done)
            ptr <= (widx == PW'(NREQ-1)) ? '0 : widx + PW'(1);
      end
   end
`endif

   // Scan downward so the candidate closest to the start position is the last to overwrite
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
`ifdef SR_BANK_SCHED_PRIORITY_EN
         if (req[k]) begin
            win_valid = 1'b1;
            win_idx   = PW'(k);
         end
`else
         if (req[(int'(ptr) + k) % NREQ]) begin
            win_valid = 1'b1;
            win_idx   = PW'((int'(ptr) + k) % NREQ);
         end
`endif
      end
      win_op   = op[2*int'(win_idx) +: 2];
      win_data = wdata[WIDTH*int'(win_idx) +: WIDTH];
   end

   // Next-state and next-output values; every output is registered one edge later
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lop_nxt   = lop;
      ldata_nxt = ldata;
      grant_nxt = grant;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      en_nxt    = 1'b0;
      d_nxt     = '0;
      s_nxt     = '0;
      r_nxt     = '0;
      case (state)
         IDLE: begin
            grant_nxt = '0;
            if (win_valid) begin
               state_nxt = DRIVE;
               cnt_nxt   = '0;
               lop_nxt   = win_op;
               ldata_nxt = win_data;
               grant_nxt = NREQ'(1) << win_idx;
               case (win_op)
                  2'b00: begin
                     en_nxt   = 1'b1;
                     d_nxt    = win_data;
                     done_nxt = 1'b1;
                  end
                  2'b01: s_nxt = win_data;
                  2'b10: r_nxt = win_data;
                  default: begin
                     done_nxt = 1'b1;
                     err_nxt  = 1'b1;
                  end
               endcase
            end
         end
         DRIVE: begin
            if (lop == 2'b00 || lop == 2'b11) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end else if (cnt == CW'(PULSE-1)) begin
               state_nxt = RECOVER;
               cnt_nxt   = '0;
               done_nxt  = (RECOVERY == 1);
            end else begin
               cnt_nxt = cnt + CW'(1);
               if (lop == 2'b01) s_nxt = ldata;
               else              r_nxt = ldata;
            end
         end
         RECOVER: begin
            if (cnt == CW'(RECOVERY-1)) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end else begin
               cnt_nxt  = cnt + CW'(1);
               done_nxt = (cnt + CW'(1) == CW'(RECOVERY-1));
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         lop     <= '0;
         ldata   <= '0;
         grant   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         bank_en <= 1'b0;
         bank_d  <= '0;
         bank_s  <= '0;
         bank_r  <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         lop     <= lop_nxt;
         ldata   <= ldata_nxt;
         grant   <= grant_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         bank_en <= en_nxt;
         bank_d  <= d_nxt;
         bank_s  <= s_nxt;
         bank_r  <= r_nxt;
      end
   end

endmodule

// File: tb/tb_sr_bank_sched.sv
// Directed self-checking bench for sr_bank_sched (NREQ=4, WIDTH=8, PULSE=2, RECOVERY=2).
module tb_sr_bank_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [31:0] wdata;
   logic [3:0]  grant;
   logic        done, err, bank_en;
   logic [7:0]  bank_d, bank_s, bank_r;

   int checks = 0;
   int passed = 0;

   sr_bank_sched #(.NREQ(4), .WIDTH(8), .PULSE(2), .RECOVERY(2)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
      .grant(grant), .done(done), .err(err), .bank_en(bank_en),
      .bank_d(bank_d), .bank_s(bank_s), .bank_r(bank_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else
         passed++;
   endtask

   task automatic applyStimulus(input int idx, input logic [1:0] o, input logic [7:0] data, input logic r);
      op[2*idx +: 2]    = o;
      wdata[8*idx +: 8] = data;
      req[idx]          = r;
   endtask

   // Bank control exclusivity is watched on every cycle
   always @(negedge clk) begin
      checkOutput("sr_exclusive", {56'd0, bank_s & bank_r}, 64'd0);
      checkOutput("en_vs_sr", {63'd0, bank_en & ((|bank_s) | (|bank_r))}, 64'd0);
   end

   initial begin
      rst = 1'b1; req = '0; op = '0; wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("reset_idle", {40'd0, grant, done, err, bank_en, bank_d, bank_s, bank_r}, 64'd0);
      end

      // Load from requester 0
      applyStimulus(0, 2'b00, 8'hA5, 1'b1);
      @(negedge clk);
      checkOutput("load_grant", {60'd0, grant}, 64'h1);
      checkOutput("load_en_d_done", {54'd0, bank_en, done, bank_d}, {54'd0, 1'b1, 1'b1, 8'hA5});
      applyStimulus(0, 2'b00, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("load_release", {49'd0, grant, done, bank_en, bank_d}, 64'd0);

      // Set 0x0F then clear 0x03 from requester 1, req held across done
      applyStimulus(1, 2'b01, 8'h0F, 1'b1);
      @(negedge clk);
      checkOutput("set_c1", {48'd0, grant, done, 3'd0, bank_s, bank_r}, {48'd0, 4'b0010, 1'b0, 3'd0, 8'h0F, 8'h00});
      applyStimulus(1, 2'b10, 8'h03, 1'b1);
      @(negedge clk);
      checkOutput("set_c2", {48'd0, grant, done, 3'd0, bank_s, bank_r}, {48'd0, 4'b0010, 1'b0, 3'd0, 8'h0F, 8'h00});
      @(negedge clk);
      checkOutput("set_rec1", {48'd0, grant, done, 3'd0, bank_s, bank_r}, {48'd0, 4'b0010, 1'b0, 3'd0, 8'h00, 8'h00});
      @(negedge clk);
      checkOutput("set_rec2_done", {48'd0, grant, done, 3'd0, bank_s, bank_r}, {48'd0, 4'b0010, 1'b1, 3'd0, 8'h00, 8'h00});
      @(negedge clk);
      checkOutput("set_idle", {59'd0, grant, done}, 64'd0);
      @(negedge clk);
      checkOutput("clr_c1", {48'd0, grant, done, 3'd0, bank_s, bank_r}, {48'd0, 4'b0010, 1'b0, 3'd0, 8'h00, 8'h03});
      applyStimulus(1, 2'b00, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("clr_c2", {56'd0, bank_r}, 64'h03);
      @(negedge clk);
      checkOutput("clr_rec1", {55'd0, done, bank_r}, 64'd0);
      @(negedge clk);
      checkOutput("clr_rec2_done", {59'd0, grant, done}, {59'd0, 4'b0010, 1'b1});

      // Fairness among four simultaneous loaders, starting from a fresh pointer
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(i, 2'b00, 8'h10 + 8'(i), 1'b1);
      for (int n = 0; n < 5; n++) begin
         int w;
`ifdef SR_BANK_SCHED_PRIORITY_EN
         w = 0;
`else
         w = n % 4;
`endif
         @(negedge clk);
         checkOutput($sformatf("rr_grant%0d", n), {60'd0, grant}, 64'(4'b0001 << w));
         checkOutput($sformatf("rr_data%0d", n), {55'd0, done, bank_d}, {55'd0, 1'b1, 8'h10 + 8'(w)});
         @(negedge clk);
         checkOutput($sformatf("rr_gap%0d", n), {59'd0, grant, done}, 64'd0);
      end
      req = '0;

      // Reset during the second set cycle; afterwards requester 0 must beat requester 1
      @(negedge clk);
      applyStimulus(0, 2'b01, 8'hFF, 1'b1);
      @(negedge clk);
      checkOutput("abort_c1", {52'd0, grant, bank_s}, {52'd0, 4'b0001, 8'hFF});
      req = '0;
      @(negedge clk);
      checkOutput("abort_c2", {56'd0, bank_s}, 64'hFF);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_release", {51'd0, grant, done, bank_s}, 64'd0);
      rst = 1'b0;
      applyStimulus(0, 2'b00, 8'h55, 1'b1);
      applyStimulus(1, 2'b00, 8'h66, 1'b1);
      @(negedge clk);
      checkOutput("ptr_reset_grant", {52'd0, grant, bank_d}, {52'd0, 4'b0001, 8'h55});
      req = '0;
      @(negedge clk);

      // Reserved opcode
      applyStimulus(2, 2'b11, 8'hEE, 1'b1);
      @(negedge clk);
      checkOutput("rsv_grant_done_err", {58'd0, grant, done, err}, {58'd0, 4'b0100, 1'b1, 1'b1});
      checkOutput("rsv_bank_zero", {39'd0, bank_en, bank_d, bank_s, bank_r}, 64'd0);
      req = '0;
      @(negedge clk);
      checkOutput("rsv_release", {58'd0, grant, done, err}, 64'd0);

      // Zero-mask set still runs the full sequence
      applyStimulus(3, 2'b01, 8'h00, 1'b1);
      @(negedge clk);
      checkOutput("zmask_grant", {60'd0, grant}, 64'h8);
      req = '0;
      repeat (2) @(negedge clk);
      checkOutput("zmask_rec1", {59'd0, grant, done}, {59'd0, 4'b1000, 1'b0});
      @(negedge clk);
      checkOutput("zmask_done", {59'd0, grant, done}, {59'd0, 4'b1000, 1'b1});
      @(negedge clk);
      checkOutput("zmask_release", {59'd0, grant, done}, 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
